// File: rtl/heart_sprite_renderer_pkg.sv
// Shared sprite/VGA definitions for the sprite renderers.
// Optional 2x scaling is selected with the SPRITE_SCALE2X_EN macro.
package heart_sprite_renderer_pkg;

   localparam int RGB_W         = 12;
   localparam int SPRITE_ROM_AW = 9;
   localparam int HEART_W       = 20;
   localparam int HEART_H       = 18;
   localparam int H_ACTIVE      = 640;
   localparam int V_ACTIVE      = 480;

   typedef logic [RGB_W-1:0] rgb_t;

   function automatic rgb_t pack_rgb(input logic [3:0] r,
                                     input logic [3:0] g,
                                     input logic [3:0] b);
      return {r, g, b};
   endfunction

   // Constant multiply built from shifted partial sums of k's set bits
   function automatic logic [SPRITE_ROM_AW-1:0] const_mul(
      input logic [SPRITE_ROM_AW-1:0] v,
      input int unsigned              k);
      logic [SPRITE_ROM_AW-1:0] acc;
      acc = '0;
      for (int i = 0; i < SPRITE_ROM_AW; i++) begin
         if (k[i]) acc = acc + (v << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/heart_sprite_renderer_sprite_addr_gen.sv
// Sprite position latch and stage-1 ROM address generation.
// SPRITE_SCALE2X_EN doubles the footprint and halves the texel step.
module sprite_addr_gen
   import heart_sprite_renderer_pkg::*;
#(
   parameter int SPRITE_W = HEART_W,
   parameter int SPRITE_H = HEART_H,
   parameter int COORD_W  = 10
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [COORD_W-1:0]       pixel_x,
   input  logic [COORD_W-1:0]       pixel_y,
   input  logic                     video_on,
   input  logic                     frame_start,
   input  logic [COORD_W-1:0]       sprite_x,
   input  logic [COORD_W-1:0]       sprite_y,
   input  logic                     sprite_en,
   output logic [SPRITE_ROM_AW-1:0] rom_address,
   output logic                     in_box
);

`ifdef SPRITE_SCALE2X_EN
   localparam int SCALE_SH = 1;
`else
   localparam int SCALE_SH = 0;
`endif
   localparam int BOX_W = SPRITE_W << SCALE_SH;
   localparam int BOX_H = SPRITE_H << SCALE_SH;

   logic [COORD_W-1:0]       lat_x;
   logic [COORD_W-1:0]       lat_y;
   logic                     lat_en;
   logic [COORD_W:0]         dx;
   logic [COORD_W:0]         dy;
   logic [SPRITE_ROM_AW-1:0] tx;
   logic [SPRITE_ROM_AW-1:0] ty;
   logic [SPRITE_ROM_AW-1:0] addr;
   logic                     hit;

   // The extra top bit of dx/dy flags underflow, so left/top edges never wrap
   always_comb begin
      dx   = {1'b0, pixel_x} - {1'b0, lat_x};
      dy   = {1'b0, pixel_y} - {1'b0, lat_y};
      tx   = SPRITE_ROM_AW'(dx >> SCALE_SH);
      ty   = SPRITE_ROM_AW'(dy >> SCALE_SH);
      hit  = lat_en & video_on & ~dx[COORD_W] & ~dy[COORD_W]
           & (dx < (COORD_W+1)'(BOX_W))
           & (dy < (COORD_W+1)'(BOX_H));
      addr = const_mul(ty, SPRITE_W) + tx;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lat_x       <= '0;
         lat_y       <= '0;
         lat_en      <= 1'b0;
         rom_address <= '0;
         in_box      <= 1'b0;
      end else begin
         if (frame_start) begin
            lat_x  <= sprite_x;
            lat_y  <= sprite_y;
            lat_en <= sprite_en;
         end
         rom_address <= hit ? addr : '0;
         in_box      <= hit;
      end
   end

endmodule

// File: rtl/heart_sprite_renderer.sv
// Heart sprite pixel stage: ROM addressing, latency alignment, compositing.
// Build with SPRITE_SCALE2X_EN to draw the sprite at 2x scale.
module heart_sprite_renderer
   import heart_sprite_renderer_pkg::*;
#(
   parameter int         SPRITE_W        = HEART_W,
   parameter int         SPRITE_H        = HEART_H,
   parameter int         COORD_W         = 10,
   parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [COORD_W-1:0]       pixel_x,
   input  logic [COORD_W-1:0]       pixel_y,
   input  logic                     video_on,
   input  logic                     frame_start,
   input  logic [COORD_W-1:0]       sprite_x,
   input  logic [COORD_W-1:0]       sprite_y,
   input  logic                     sprite_en,
   input  logic [RGB_W-1:0]         bg_rgb,
   output logic [SPRITE_ROM_AW-1:0] rom_address,
   input  logic [7:0]               rom_r,
   input  logic [7:0]               rom_g,
   input  logic [7:0]               rom_b,
   output logic [RGB_W-1:0]         pixel_rgb,
   output logic                     pixel_valid,
   output logic                     sprite_hit
);

   logic             in_box_d1;
   logic             video_d1;
   rgb_t             bg_d1;
   logic             in_box_d2;
   logic             video_d2;
   rgb_t             bg_d2;
   rgb_t             spr;
   logic             opaque;
   logic             unused_rom_hi;

   sprite_addr_gen #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .COORD_W  (COORD_W)
   ) u_addr (
      .clock       (clock),
      .reset       (reset),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .video_on    (video_on),
      .frame_start (frame_start),
      .sprite_x    (sprite_x),
      .sprite_y    (sprite_y),
      .sprite_en   (sprite_en),
      .rom_address (rom_address),
      .in_box      (in_box_d1)
   );

   // ROM words are 8 bits wide but only the low nibble carries colour
   assign unused_rom_hi = ^{rom_r[7:4], rom_g[7:4], rom_b[7:4]};

   always_comb begin
      spr    = pack_rgb(rom_r[3:0], rom_g[3:0], rom_b[3:0]);
      opaque = in_box_d2 & (spr != TRANSPARENT_KEY);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         video_d1    <= 1'b0;
         bg_d1       <= '0;
         in_box_d2   <= 1'b0;
         video_d2    <= 1'b0;
         bg_d2       <= '0;
         pixel_rgb   <= '0;
         pixel_valid <= 1'b0;
         sprite_hit  <= 1'b0;
      end else begin
         video_d1    <= video_on;
         bg_d1       <= bg_rgb;
         in_box_d2   <= in_box_d1;
         video_d2    <= video_d1;
         bg_d2       <= bg_d1;
         pixel_rgb   <= !video_d2 ? '0 : (opaque ? spr : bg_d2);
         pixel_valid <= video_d2;
         sprite_hit  <= opaque & video_d2;
      end
   end

endmodule
